mem_copy_initiator: RTL and testbench
=====================================

Name: mem_copy_initiator

Overview:
- Request-side master for the single-cycle word memory interface: valid/ready request channel, one-cycle-latency read response, writes carry no response.
- Copies a block of LEN 32-bit words from a source word address to a destination word address.
- Issues strictly one request at a time: read, wait for the response, then write.
- Sits between a control register block (start/status) and the memory port; used for memory init/copy and as a bench driver for the memory model.

Parameters:
- CPU_WIDTH, 32, data word width in bits; byte-enable width is CPU_WIDTH/8 = 4.
- WORD_ADDR_BITS, 30, word address width (byte address width 32 minus 2).
- LEN_BITS, 16, width of length and progress counters.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; sampled only in IDLE.
- src_addr  input  WORD_ADDR_BITS  source word address; latched on accepted start.
- dst_addr  input  WORD_ADDR_BITS  destination word address; latched on accepted start.
- len  input  LEN_BITS  number of words to copy; latched on accepted start.
- busy  output  1  high in RD_REQ, RD_WAIT and WR_REQ.
- done  output  1  one-cycle completion pulse.
- words_done  output  LEN_BITS  count of words written in the current or last transfer.
- mem_req_valid  output  1  request valid.
- mem_req_ready  input  1  memory accepts the request; fire = valid & ready.
- mem_req_addr  output  WORD_ADDR_BITS  request word address.
- mem_req_data  output  CPU_WIDTH  write data.
- mem_req_write  output  4  byte write enables; 0000 = read.
- mem_resp_valid  input  1  read data valid.
- mem_resp_data  input  CPU_WIDTH  read data.

Behaviour:
- Reset (asynchronous, immediate):
  - State goes to IDLE; all counters and registers clear.
  - Outputs: busy=0, done=0, words_done=0, mem_req_valid=0, mem_req_addr=0, mem_req_data=0, mem_req_write=0.
  - Reset mid-transfer abandons the transfer at once; no further requests are issued. A request already accepted by memory is not retracted.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE.
- IDLE:
  - On start=1: latch src, dst and len; clear words_done.
  - len!=0: go to RD_REQ. len==0: go to DONE, with no memory traffic.
- RD_REQ:
  - mem_req_valid=1, mem_req_addr=src_ptr, mem_req_write=0000.
  - On fire: go to RD_WAIT.
  - Hold valid, addr and write stable while ready=0.
- RD_WAIT:
  - mem_req_valid=0.
  - On mem_resp_valid: capture mem_resp_data into the data register, then go to WR_REQ.
  - Wait indefinitely for the response; no timeout.
- WR_REQ:
  - mem_req_valid=1, mem_req_addr=dst_ptr, mem_req_data=data register, mem_req_write=1111.
  - On fire: src_ptr+1 and dst_ptr+1, both modulo 2^WORD_ADDR_BITS (wrap, no error); words_done+1.
  - If the incremented words_done == len, go to DONE; otherwise go to RD_REQ.
- DONE: done=1 for exactly one cycle, then IDLE.
- Ignored events:
  - start outside IDLE, including in DONE.
  - mem_resp_valid in any state other than RD_WAIT (stray or write-side responses).
- Throughput with ready=1 and 1-cycle response latency: 3 cycles per word.
- Timing: start sampled at edge t gives RD_REQ in cycle t+1; done is high in cycle t+1+3*len. For len==0, done is high in cycle t+1.
- mem_req_data holds the last written value outside WR_REQ; its value is don't-care when valid=0.
- words_done holds its final value after done, until the next accepted start.

Optional Feature:
- Macro MEM_COPY_CHECKSUM_EN.
- When defined:
  - Adds output checksum (CPU_WIDTH bits).
  - Cleared on accepted start and on reset.
  - On each WR_REQ fire: checksum = checksum + written data, modulo 2^CPU_WIDTH.
  - Stable from the done pulse until the next accepted start.
- When undefined: no checksum port and no adder; all other behaviour is identical.

Test Plan:
- Basic copy:
  - Stimulus: memory words 0x100..0x103 = 0x11111111, 0x22222222, 0x33333333, 0x44444444; src=0x100, dst=0x200, len=4, ready=1.
  - Response: 0x200..0x203 hold the same values; done pulse exactly 13 cycles after start; words_done=4; with MEM_COPY_CHECKSUM_EN, checksum=0xAAAAAAAA.
- Backpressure:
  - Stimulus: ready toggles 0,0,1 per request.
  - Response: valid, addr, write and data stable while ready=0; same final memory contents; each word takes 7 cycles.
- len=0:
  - Stimulus: start with len=0.
  - Response: done is high the cycle after start; mem_req_valid never asserts; words_done=0.
- Address wrap:
  - Stimulus: src=0x3FFFFFFF, dst=0x10, len=2.
  - Response: reads issued to addresses 0x3FFFFFFF then 0x00000000; writes to 0x10 and 0x11.
- Ignored inputs:
  - Stimulus: start pulse while busy; a mem_resp_valid pulse during RD_REQ.
  - Response: no change to latched operands or sequence; the spurious data is not written.
- Reset mid-transfer:
  - Stimulus: assert reset during WR_REQ of word 2 of len=8, then release and start len=1.
  - Response: all outputs 0 immediately on reset; the new copy completes with words_done=1.

Source files
------------

// File: rtl/mem_copy_initiator.sv
// Single-outstanding word copy engine: read one word, wait for its response, write it, repeat.
// Define MEM_COPY_CHECKSUM_EN to add a running modular sum of every written word on port checksum.
module mem_copy_initiator #(
    parameter int CPU_WIDTH      = 32,
    parameter int WORD_ADDR_BITS = 30,
    parameter int LEN_BITS       = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [WORD_ADDR_BITS-1:0] src_addr,
    input  logic [WORD_ADDR_BITS-1:0] dst_addr,
    input  logic [LEN_BITS-1:0]       len,
    output logic                      busy,
    output logic                      done,
    output logic [LEN_BITS-1:0]       words_done,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic [WORD_ADDR_BITS-1:0] mem_req_addr,
    output logic [CPU_WIDTH-1:0]      mem_req_data,
    output logic [CPU_WIDTH/8-1:0]    mem_req_write,
    input  logic                      mem_resp_valid,
    input  logic [CPU_WIDTH-1:0]      mem_resp_data
`ifdef MEM_COPY_CHECKSUM_EN
    ,
    output logic [CPU_WIDTH-1:0]      checksum
`endif
);

    localparam int BE_W = CPU_WIDTH / 8;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_REQ  = 3'd1;
    localparam logic [2:0] S_RD_WAIT = 3'd2;
    localparam logic [2:0] S_WR_REQ  = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0]                state_q, state_d;
    logic [WORD_ADDR_BITS-1:0] src_ptr_q, src_ptr_d;
    logic [WORD_ADDR_BITS-1:0] dst_ptr_q, dst_ptr_d;
    logic [LEN_BITS-1:0]       len_q, len_d;
    logic [LEN_BITS-1:0]       words_done_q, words_done_d;
    logic [LEN_BITS-1:0]       words_done_inc;
    logic [CPU_WIDTH-1:0]      data_q, data_d;
`ifdef MEM_COPY_CHECKSUM_EN
    logic [CPU_WIDTH-1:0]      checksum_q, checksum_d;
`endif

    logic in_idle;
    logic in_rd_req;
    logic in_rd_wait;
    logic in_wr_req;

    assign in_idle    = (state_q == S_IDLE);
    assign in_rd_req  = (state_q == S_RD_REQ);
    assign in_rd_wait = (state_q == S_RD_WAIT);
    assign in_wr_req  = (state_q == S_WR_REQ);

    assign words_done_inc = words_done_q + LEN_BITS'(1);

    // Request outputs decode straight from state so an async reset drops them immediately.
    assign busy          = in_rd_req | in_rd_wait | in_wr_req;
    assign done          = (state_q == S_DONE);
    assign words_done    = words_done_q;
    assign mem_req_valid = in_rd_req | in_wr_req;
    assign mem_req_addr  = in_rd_req ? src_ptr_q :
                           in_wr_req ? dst_ptr_q : '0;
    assign mem_req_data  = data_q;
    assign mem_req_write = {BE_W{in_wr_req}};
`ifdef MEM_COPY_CHECKSUM_EN
    assign checksum      = checksum_q;
`endif

    always_comb begin
        state_d      = state_q;
        src_ptr_d    = src_ptr_q;
        dst_ptr_d    = dst_ptr_q;
        len_d        = len_q;
        words_done_d = words_done_q;
        data_d       = data_q;
`ifdef MEM_COPY_CHECKSUM_EN
        checksum_d   = checksum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_ptr_d    = src_addr;
                    dst_ptr_d    = dst_addr;
                    len_d        = len;
                    words_done_d = '0;
`ifdef MEM_COPY_CHECKSUM_EN
                    checksum_d   = '0;
`endif
                    state_d      = (len == '0) ? S_DONE : S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                if (mem_req_ready) begin
                    state_d = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                // Responses arriving in any other state are stray and never sampled.
                if (mem_resp_valid) begin
                    data_d  = mem_resp_data;
                    state_d = S_WR_REQ;
                end
            end
            S_WR_REQ: begin
                if (mem_req_ready) begin
                    src_ptr_d    = src_ptr_q + WORD_ADDR_BITS'(1);
                    dst_ptr_d    = dst_ptr_q + WORD_ADDR_BITS'(1);
                    words_done_d = words_done_inc;
`ifdef MEM_COPY_CHECKSUM_EN
                    checksum_d   = checksum_q + data_q;
`endif
                    state_d      = (words_done_inc == len_q) ? S_DONE : S_RD_REQ;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            src_ptr_q    <= '0;
            dst_ptr_q    <= '0;
            len_q        <= '0;
            words_done_q <= '0;
            data_q       <= '0;
`ifdef MEM_COPY_CHECKSUM_EN
            checksum_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            src_ptr_q    <= src_ptr_d;
            dst_ptr_q    <= dst_ptr_d;
            len_q        <= len_d;
            words_done_q <= words_done_d;
            data_q       <= data_d;
`ifdef MEM_COPY_CHECKSUM_EN
            checksum_q   <= checksum_d;
`endif
        end
    end

    // Unused in the default build; keeps idle decode visible for future status use.
    logic unused_idle;
    assign unused_idle = in_idle;

endmodule

// File: tb/tb_mem_copy_initiator.sv
// Randomized self-checking bench for mem_copy_initiator with a 1-cycle word memory model.
// The reference model computes expected memory, request order and timing from the copy rules.
module tb_mem_copy_initiator;

    localparam int CW = 32;
    localparam int AW = 30;
    localparam int LW = 16;

    logic          clk;
    logic          reset;
    logic          start;
    logic [AW-1:0] src_addr;
    logic [AW-1:0] dst_addr;
    logic [LW-1:0] len;
    logic          busy;
    logic          done;
    logic [LW-1:0] words_done;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic [AW-1:0] mem_req_addr;
    logic [CW-1:0] mem_req_data;
    logic [3:0]    mem_req_write;
    logic          mem_resp_valid;
    logic [CW-1:0] mem_resp_data;
`ifdef MEM_COPY_CHECKSUM_EN
    logic [CW-1:0] checksum;
`endif

    mem_copy_initiator dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .src_addr      (src_addr),
        .dst_addr      (dst_addr),
        .len           (len),
        .busy          (busy),
        .done          (done),
        .words_done    (words_done),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_req_data  (mem_req_data),
        .mem_req_write (mem_req_write),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_data (mem_resp_data)
`ifdef MEM_COPY_CHECKSUM_EN
        ,
        .checksum      (checksum)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [CW-1:0] data;
    } req_t;

    // Memory model: 1024 words aliased on the low 10 address bits.
    logic [CW-1:0] mem [0:1023];
    logic          resp_valid_m = 1'b0;
    logic [CW-1:0] resp_data_m  = '0;
    logic          inj_valid;
    logic [CW-1:0] inj_data;
    int            ready_mode;
    int unsigned   wait_cnt     = 0;
    logic          rand_ready   = 1'b1;
    logic          fill_req;
    logic          poke_en;
    logic [9:0]    poke_idx;
    logic [CW-1:0] poke_data;
    req_t          log_q[$];

    assign mem_req_ready  = (ready_mode == 0) ? 1'b1 :
                            (ready_mode == 1) ? (wait_cnt == 2) : rand_ready;
    assign mem_resp_valid = resp_valid_m | inj_valid;
    assign mem_resp_data  = inj_valid ? inj_data : resp_data_m;

    always @(posedge clk) begin
        resp_valid_m <= 1'b0;
        rand_ready   <= 1'($urandom_range(0, 1));
        if (mem_req_valid && !mem_req_ready) wait_cnt <= wait_cnt + 1;
        else                                 wait_cnt <= 0;
        if (fill_req) begin
            for (int i = 0; i < 1024; i++) mem[i] <= $urandom();
        end else if (poke_en) begin
            mem[poke_idx] <= poke_data;
        end
        if (mem_req_valid && mem_req_ready) begin
            log_q.push_back('{wr: (mem_req_write != 4'h0), addr: mem_req_addr, data: mem_req_data});
            if (mem_req_write != 4'h0) begin
                mem[mem_req_addr[9:0]] <= mem_req_data;
            end else begin
                resp_valid_m <= 1'b1;
                resp_data_m  <= mem[mem_req_addr[9:0]];
            end
        end
    end

    // Counts cycles where a stalled request changed before being accepted.
    logic          stall_prev = 1'b0;
    logic [AW-1:0] prev_addr  = '0;
    logic [3:0]    prev_wr    = '0;
    logic [CW-1:0] prev_data  = '0;
    int            stall_viol = 0;

    always @(negedge clk) begin
        if (stall_prev && !reset) begin
            if (!mem_req_valid || mem_req_addr !== prev_addr || mem_req_write !== prev_wr ||
                (prev_wr != 4'h0 && mem_req_data !== prev_data))
                stall_viol <= stall_viol + 1;
        end
        stall_prev <= mem_req_valid && !mem_req_ready && !reset;
        prev_addr  <= mem_req_addr;
        prev_wr    <= mem_req_write;
        prev_data  <= mem_req_data;
    end

    // Reference model state.
    logic [CW-1:0] exp_mem [0:1023];
    req_t          exp_log[$];
    logic [CW-1:0] exp_sum;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic build_expected(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [LW-1:0] n);
        logic [AW-1:0] ra;
        logic [AW-1:0] wa;
        logic [CW-1:0] v;
        exp_mem = mem;
        exp_sum = '0;
        exp_log.delete();
        for (int i = 0; i < int'(n); i++) begin
            ra = s + AW'(i);
            wa = d + AW'(i);
            v  = exp_mem[ra[9:0]];
            exp_log.push_back('{wr: 1'b0, addr: ra, data: '0});
            exp_log.push_back('{wr: 1'b1, addr: wa, data: v});
            exp_mem[wa[9:0]] = v;
            exp_sum = exp_sum + v;
        end
    endtask

    function automatic int count_mem_diffs();
        int diffs = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== exp_mem[i]) diffs++;
        return diffs;
    endfunction

    function automatic int count_log_diffs(input int base);
        int diffs = 0;
        if (log_q.size() - base != exp_log.size()) diffs++;
        for (int i = 0; i < exp_log.size(); i++) begin
            if (base + i >= log_q.size()) diffs++;
            else if (log_q[base+i].wr !== exp_log[i].wr || log_q[base+i].addr !== exp_log[i].addr) diffs++;
            else if (exp_log[i].wr && log_q[base+i].data !== exp_log[i].data) diffs++;
        end
        return diffs;
    endfunction

    task automatic fill_mem();
        @(negedge clk);
        fill_req = 1'b1;
        @(negedge clk);
        fill_req = 1'b0;
    endtask

    task automatic poke(input logic [9:0] idx, input logic [CW-1:0] data);
        @(negedge clk);
        poke_en   = 1'b1;
        poke_idx  = idx;
        poke_data = data;
        @(negedge clk);
        poke_en   = 1'b0;
    endtask

    // Starts one copy; cycles is the cycle index (1 = cycle after the start edge) of done.
    task automatic run_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [LW-1:0] n,
                            input int inj_start_k, input bit inj_resp,
                            output int cycles, output bit timed_out, output bit done_again,
                            output bit injected);
        int k;
        @(negedge clk);
        src_addr = s;
        dst_addr = d;
        len      = n;
        start    = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        src_addr  = AW'($urandom());
        dst_addr  = AW'($urandom());
        len       = LW'($urandom());
        cycles    = -1;
        injected  = 1'b0;
        k         = 1;
        while (k < 3000) begin
            start = (k == inj_start_k);
            if (start) len = 16'd5;
            if (inj_resp && !injected && mem_req_valid && mem_req_write == 4'h0 && !mem_req_ready) begin
                inj_valid = 1'b1;
                inj_data  = 32'hDEADBEEF;
                injected  = 1'b1;
            end else begin
                inj_valid = 1'b0;
            end
            if (done) begin
                cycles = k;
                break;
            end
            @(negedge clk);
            k++;
        end
        timed_out = (cycles < 0);
        @(negedge clk);
        done_again = done;
        start      = 1'b0;
        inj_valid  = 1'b0;
        $display("[TB] copy src=%08h dst=%08h len=%0d ready_mode=%0d cycles=%0d words_done=%0d",
                 s, d, n, ready_mode, cycles, words_done);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || mem_req_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl busy=%b done=%b valid=%b required 0 0 0", busy, done, mem_req_valid);
        end
        tests_run++;
        if (words_done !== '0 || mem_req_addr !== '0 || mem_req_data !== '0 || mem_req_write !== '0) begin
            tests_failed++;
            $display("FAIL reset_data words_done=%0d addr=%h data=%h write=%b required all 0",
                     words_done, mem_req_addr, mem_req_data, mem_req_write);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int cyc; bit to, again, inj; int base;
        ready_mode = 0;
        poke(10'h100, 32'h11111111);
        poke(10'h101, 32'h22222222);
        poke(10'h102, 32'h33333333);
        poke(10'h103, 32'h44444444);
        build_expected(30'h100, 30'h200, 16'd4);
        base = log_q.size();
        run_copy(30'h100, 30'h200, 16'd4, 0, 1'b0, cyc, to, again, inj);
        tests_run++;
        if (to || cyc != 13) begin
            tests_failed++;
            $display("FAIL basic_latency done at cycle %0d required 13", cyc);
        end
        tests_run++;
        if (again !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_done_width done=%b one cycle later required 0", again);
        end
        tests_run++;
        if (words_done !== 16'd4) begin
            tests_failed++;
            $display("FAIL basic_words_done got %0d required 4", words_done);
        end
        tests_run++;
        if (count_mem_diffs() != 0) begin
            tests_failed++;
            $display("FAIL basic_mem %0d words differ required 0 (dst[0]=%h)", count_mem_diffs(), mem[10'h200]);
        end
        tests_run++;
        if (count_log_diffs(base) != 0) begin
            tests_failed++;
            $display("FAIL basic_reqs %0d request differences required 0", count_log_diffs(base));
        end
`ifdef MEM_COPY_CHECKSUM_EN
        tests_run++;
        if (checksum !== 32'hAAAAAAAA) begin
            tests_failed++;
            $display("FAIL basic_checksum got %h required aaaaaaaa", checksum);
        end
`endif
    endtask

    task automatic test_backpressure();
        int cyc; bit to, again, inj; int base; int viol0;
        logic [AW-1:0] s; logic [AW-1:0] d;
        ready_mode = 1;
        fill_mem();
        s = {20'($urandom()), 10'h040};
        d = {20'($urandom()), 10'h2C0};
        build_expected(s, d, 16'd3);
        base  = log_q.size();
        viol0 = stall_viol;
        run_copy(s, d, 16'd3, 0, 1'b0, cyc, to, again, inj);
        tests_run++;
        if (to || cyc != 22) begin
            tests_failed++;
            $display("FAIL bp_latency done at cycle %0d required 22", cyc);
        end
        tests_run++;
        if (stall_viol != viol0) begin
            tests_failed++;
            $display("FAIL bp_stable %0d unstable stalled cycles required 0", stall_viol - viol0);
        end
        tests_run++;
        if (count_mem_diffs() != 0 || count_log_diffs(base) != 0) begin
            tests_failed++;
            $display("FAIL bp_copy mem diffs %0d req diffs %0d required 0 0", count_mem_diffs(), count_log_diffs(base));
        end
    endtask

    task automatic test_len_zero();
        int cyc; bit to, again, inj; int base;
        ready_mode = 0;
        base = log_q.size();
        // A second start is raised during the DONE cycle and must be ignored.
        run_copy(30'h123, 30'h321, 16'd0, 1, 1'b0, cyc, to, again, inj);
        tests_run++;
        if (to || cyc != 1) begin
            tests_failed++;
            $display("FAIL len0_latency done at cycle %0d required 1", cyc);
        end
        tests_run++;
        if (words_done !== 16'd0) begin
            tests_failed++;
            $display("FAIL len0_words_done got %0d required 0", words_done);
        end
        repeat (4) @(negedge clk);
        tests_run++;
        if (log_q.size() != base || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL len0_no_traffic requests=%0d busy=%b required 0 0", log_q.size() - base, busy);
        end
    endtask

    task automatic test_wrap();
        int cyc; bit to, again, inj; int base;
        ready_mode = 0;
        fill_mem();
        build_expected(30'h3FFFFFFF, 30'h10, 16'd2);
        base = log_q.size();
        run_copy(30'h3FFFFFFF, 30'h10, 16'd2, 0, 1'b0, cyc, to, again, inj);
        tests_run++;
        if (to || log_q.size() < base + 4 || log_q[base].addr !== 30'h3FFFFFFF || log_q[base+2].addr !== 30'h0) begin
            tests_failed++;
            $display("FAIL wrap_read_addr second read address wrong or missing, required 3fffffff then 00000000");
        end
        tests_run++;
        if (count_log_diffs(base) != 0 || count_mem_diffs() != 0) begin
            tests_failed++;
            $display("FAIL wrap_copy req diffs %0d mem diffs %0d required 0 0", count_log_diffs(base), count_mem_diffs());
        end
    endtask

    task automatic test_ignored();
        int cyc; bit to, again, inj; int base;
        logic [AW-1:0] s; logic [AW-1:0] d;
        ready_mode = 1;
        fill_mem();
        s = {20'($urandom()), 10'h080};
        d = {20'($urandom()), 10'h300};
        build_expected(s, d, 16'd4);
        base = log_q.size();
        run_copy(s, d, 16'd4, 3, 1'b1, cyc, to, again, inj);
        tests_run++;
        if (inj !== 1'b1) begin
            tests_failed++;
            $display("FAIL ign_setup stray response injected=%b required 1", inj);
        end
        tests_run++;
        if (to || cyc != 29) begin
            tests_failed++;
            $display("FAIL ign_latency done at cycle %0d required 29", cyc);
        end
        tests_run++;
        if (count_mem_diffs() != 0 || count_log_diffs(base) != 0) begin
            tests_failed++;
            $display("FAIL ign_copy mem diffs %0d req diffs %0d required 0 0", count_mem_diffs(), count_log_diffs(base));
        end
        repeat (6) @(negedge clk);
        tests_run++;
        if (words_done !== 16'd4 || busy !== 1'b0 || log_q.size() != base + 8) begin
            tests_failed++;
            $display("FAIL ign_hold words_done=%0d busy=%b requests=%0d required 4 0 8",
                     words_done, busy, log_q.size() - base);
        end
    endtask

    task automatic test_reset_mid();
        int cyc; bit to, again, inj; int base; int log_sz; bit found;
        logic [AW-1:0] s; logic [AW-1:0] d;
        ready_mode = 0;
        fill_mem();
        s = {20'($urandom()), 10'h010};
        d = {20'($urandom()), 10'h210};
        @(negedge clk);
        src_addr = s; dst_addr = d; len = 16'd8; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (mem_req_valid && mem_req_write == 4'hF && words_done == 16'd1) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        tests_run++;
        if (!found) begin
            tests_failed++;
            $display("FAIL rstmid_setup second write not reached, words_done=%0d", words_done);
        end
        #2 reset = 1'b1;
        #1;
        $display("[TB] async reset asserted mid-transfer");
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || mem_req_valid !== 1'b0 || mem_req_write !== 4'h0) begin
            tests_failed++;
            $display("FAIL rstmid_ctrl busy=%b done=%b valid=%b write=%b required all 0",
                     busy, done, mem_req_valid, mem_req_write);
        end
        tests_run++;
        if (words_done !== '0 || mem_req_addr !== '0 || mem_req_data !== '0) begin
            tests_failed++;
            $display("FAIL rstmid_data words_done=%0d addr=%h data=%h required all 0",
                     words_done, mem_req_addr, mem_req_data);
        end
`ifdef MEM_COPY_CHECKSUM_EN
        tests_run++;
        if (checksum !== '0) begin
            tests_failed++;
            $display("FAIL rstmid_checksum got %h required 0", checksum);
        end
`endif
        @(negedge clk);
        @(negedge clk);
        log_sz = log_q.size();
        reset  = 1'b0;
        repeat (5) @(negedge clk);
        tests_run++;
        if (log_q.size() != log_sz || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_abandon requests=%0d busy=%b after reset required 0 0", log_q.size() - log_sz, busy);
        end
        build_expected(d + AW'(40), s + AW'(40), 16'd1);
        base = log_q.size();
        run_copy(d + AW'(40), s + AW'(40), 16'd1, 0, 1'b0, cyc, to, again, inj);
        tests_run++;
        if (to || cyc != 4 || words_done !== 16'd1 || count_mem_diffs() != 0 || count_log_diffs(base) != 0) begin
            tests_failed++;
            $display("FAIL rstmid_recopy cycle=%0d words_done=%0d mem diffs=%0d required 4 1 0",
                     cyc, words_done, count_mem_diffs());
        end
    endtask

    task automatic test_random();
        int cyc; bit to, again, inj; int base; int exp_cyc;
        logic [AW-1:0] s; logic [AW-1:0] d; logic [LW-1:0] n;
        for (int it = 0; it < 8; it++) begin
            ready_mode = int'($urandom_range(0, 2));
            fill_mem();
            s = {20'($urandom()), 10'($urandom_range(0, 10'h1F0))};
            d = {20'($urandom()), 10'($urandom_range(10'h200, 10'h3F0))};
            n = LW'($urandom_range(1, 12));
            build_expected(s, d, n);
            base = log_q.size();
            run_copy(s, d, n, 0, 1'b0, cyc, to, again, inj);
            exp_cyc = (ready_mode == 0) ? 1 + 3 * int'(n) : (ready_mode == 1) ? 1 + 7 * int'(n) : cyc;
            tests_run++;
            if (to || cyc != exp_cyc || words_done !== n) begin
                tests_failed++;
                $display("FAIL rand_%0d done cycle=%0d words_done=%0d required %0d %0d", it, cyc, words_done, exp_cyc, n);
            end
            tests_run++;
            if (count_mem_diffs() != 0 || count_log_diffs(base) != 0) begin
                tests_failed++;
                $display("FAIL rand_%0d_copy mem diffs %0d req diffs %0d required 0 0",
                         it, count_mem_diffs(), count_log_diffs(base));
            end
`ifdef MEM_COPY_CHECKSUM_EN
            tests_run++;
            if (checksum !== exp_sum) begin
                tests_failed++;
                $display("FAIL rand_%0d_checksum got %h required %h", it, checksum, exp_sum);
            end
`endif
        end
    endtask

    initial begin
        start      = 1'b0;
        src_addr   = '0;
        dst_addr   = '0;
        len        = '0;
        inj_valid  = 1'b0;
        inj_data   = '0;
        ready_mode = 0;
        fill_req   = 1'b0;
        poke_en    = 1'b0;
        poke_idx   = '0;
        poke_data  = '0;
        test_reset();
        fill_mem();
        test_basic();
        test_backpressure();
        test_len_zero();
        test_wrap();
        test_ignored();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
